// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the Hamming(7,4) SECDED encoder/decoder pair.
//   - codeword bit layout (bit i holds Hamming position i+1)
//   - decoder status encoding
//   - syndrome / data widths
//   - encoder helper and data extraction helper
`timescale 1ns/1ps
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Codeword layout, LSB first: p1, p2, d0, p4, d1, d2, d3
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D0 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D1 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;

    typedef enum logic [1:0] {
        ST_CLEAN = 2'b00,  // no error
        ST_CORR  = 2'b01,  // single code-bit error, corrected
        ST_PAR   = 2'b10,  // overall parity bit alone was wrong
        ST_DED   = 2'b11   // double error, uncorrectable
    } status_e;

    // Data nibble {d3,d2,d1,d0} pulled out of a codeword.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        return {c[POS_D3], c[POS_D2], c[POS_D1], c[POS_D0]};
    endfunction

    // Encoder side: place data bits and compute the three check bits.
    function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c         = '0;
        c[POS_D0] = d[0];
        c[POS_D1] = d[1];
        c[POS_D2] = d[2];
        c[POS_D3] = d[3];
        c[POS_P1] = d[0] ^ d[1] ^ d[3];
        c[POS_P2] = d[0] ^ d[2] ^ d[3];
        c[POS_P4] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// hamming74_syndrome
// Combinational syndrome and overall-parity-error computation.
// Ports:
//   i_code   [6:0]  received codeword (bit i = Hamming position i+1)
//   i_parity        received overall parity bit
//   o_syn    [2:0]  {s4,s2,s1}: failing Hamming position, 0 if none
//   o_pe            1 when the overall parity check fails
`timescale 1ns/1ps
module hamming74_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_parity,
    output logic [SYN_W-1:0]  o_syn,
    output logic              o_pe
);

    logic s1, s2, s4;

    // Each check bit covers the positions whose index has that bit set.
    assign s1 = i_code[POS_P1] ^ i_code[POS_D0] ^ i_code[POS_D1] ^ i_code[POS_D3];
    assign s2 = i_code[POS_P2] ^ i_code[POS_D0] ^ i_code[POS_D2] ^ i_code[POS_D3];
    assign s4 = i_code[POS_P4] ^ i_code[POS_D1] ^ i_code[POS_D2] ^ i_code[POS_D3];

    assign o_syn = {s4, s2, s1};
    assign o_pe  = (^i_code) ^ i_parity;

endmodule

// File: rtl/hamming74_dec.sv
// hamming74_dec
// Two-stage pipelined SECDED decoder for Hamming(7,4) plus overall parity,
// with valid/ready on both sides and saturating error counters.
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_valid / o_ready       input handshake
//   i_hamming_code, i_parity received codeword and overall parity
//   o_valid / i_ready       output handshake
//   o_data, o_status        corrected data and decode status
//   o_err_pos               syndrome (failing Hamming position, 0 if none)
//   i_cnt_clr               synchronous clear of both counters
//   o_cnt_corr              corrected (status 01/10) words delivered
//   o_cnt_uncorr            uncorrectable (status 11) words delivered
`timescale 1ns/1ps
module hamming74_dec
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [6:0]       i_hamming_code,
    input  logic             i_parity,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [3:0]       o_data,
    output logic [1:0]       o_status,
    output logic [2:0]       o_err_pos,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_cnt_corr,
    output logic [CNT_W-1:0] o_cnt_uncorr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // One-hot mask selecting the code bit named by a non-zero syndrome.
    function automatic logic [CODE_W-1:0] flip_mask(input logic [SYN_W-1:0] syn);
        if (syn == '0) begin
            return '0;
        end
        return CODE_W'(1) << (syn - SYN_W'(1));
    endfunction

    logic              adv1, adv2;
    logic [SYN_W-1:0]  syn_in;
    logic              pe_in;
    logic              out_hs;

    logic              vld_p1_q, vld_p1_d;
    logic [CODE_W-1:0] code_p1_q, code_p1_d;
    logic [SYN_W-1:0]  syn_p1_q, syn_p1_d;
    logic              pe_p1_q, pe_p1_d;

    logic              vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    status_e           status_p2_q, status_p2_d;
    logic [SYN_W-1:0]  err_pos_p2_q, err_pos_p2_d;

    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    hamming74_syndrome u_syndrome (
        .i_code   (i_hamming_code),
        .i_parity (i_parity),
        .o_syn    (syn_in),
        .o_pe     (pe_in)
    );

    // A stage may take new contents when it is empty or its contents leave.
    assign adv2    = !vld_p2_q || i_ready;
    assign adv1    = !vld_p1_q || adv2;
    assign o_ready = adv1;
    assign out_hs  = vld_p2_q && i_ready;

    // ---- stage 1: capture code, syndrome and parity error ----
    always_comb begin
        vld_p1_d  = vld_p1_q;
        code_p1_d = code_p1_q;
        syn_p1_d  = syn_p1_q;
        pe_p1_d   = pe_p1_q;
        if (adv1) begin
            vld_p1_d = i_valid;
            if (i_valid) begin
                code_p1_d = i_hamming_code;
                syn_p1_d  = syn_in;
                pe_p1_d   = pe_in;
            end
        end
    end

    // ---- stage 2: classify, correct, present output ----
    always_comb begin
        vld_p2_d     = vld_p2_q;
        data_p2_d    = data_p2_q;
        status_p2_d  = status_p2_q;
        err_pos_p2_d = err_pos_p2_q;
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                err_pos_p2_d = syn_p1_q;
                data_p2_d    = extract_data(code_p1_q);
                unique case ({pe_p1_q, syn_p1_q != '0})
                    2'b00: status_p2_d = ST_CLEAN;
                    2'b10: status_p2_d = ST_PAR;
                    2'b01: status_p2_d = ST_DED;   // even number of flips, cannot locate
                    default: begin
                        status_p2_d = ST_CORR;
                        data_p2_d   = extract_data(code_p1_q ^ flip_mask(syn_p1_q));
                    end
                endcase
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (i_cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_hs) begin
            if (status_p2_q == ST_CORR || status_p2_q == ST_PAR) begin
                cnt_corr_d = sat_inc(cnt_corr_q);
            end
            if (status_p2_q == ST_DED) begin
                cnt_uncorr_d = sat_inc(cnt_uncorr_q);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1_q     <= 1'b0;
            code_p1_q    <= '0;
            syn_p1_q     <= '0;
            pe_p1_q      <= 1'b0;
            vld_p2_q     <= 1'b0;
            data_p2_q    <= '0;
            status_p2_q  <= ST_CLEAN;
            err_pos_p2_q <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            code_p1_q    <= code_p1_d;
            syn_p1_q     <= syn_p1_d;
            pe_p1_q      <= pe_p1_d;
            vld_p2_q     <= vld_p2_d;
            data_p2_q    <= data_p2_d;
            status_p2_q  <= status_p2_d;
            err_pos_p2_q <= err_pos_p2_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign o_valid      = vld_p2_q;
    assign o_data       = data_p2_q;
    assign o_status     = status_p2_q;
    assign o_err_pos    = err_pos_p2_q;
    assign o_cnt_corr   = cnt_corr_q;
    assign o_cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_hamming74_dec.sv
`timescale 1ns/1ps
module tb_hamming74_dec;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [6:0]       i_hamming_code;
    logic             i_parity;
    logic             o_valid;
    logic             i_ready;
    logic [3:0]       o_data;
    logic [1:0]       o_status;
    logic [2:0]       o_err_pos;
    logic             i_cnt_clr;
    logic [CNT_W-1:0] o_cnt_corr;
    logic [CNT_W-1:0] o_cnt_uncorr;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [6:0] code;
        logic       par;
        logic [3:0] d;
        logic [1:0] st;
        logic [2:0] pos;
        logic [1:0] corr;
        logic [1:0] unc;
    } vec_t;

    always #5 clk = ~clk;

    hamming74_dec #(.CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_hamming_code (i_hamming_code),
        .i_parity       (i_parity),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_status       (o_status),
        .o_err_pos      (o_err_pos),
        .i_cnt_clr      (i_cnt_clr),
        .o_cnt_corr     (o_cnt_corr),
        .o_cnt_uncorr   (o_cnt_uncorr)
    );

    task automatic test_reset();
        i_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        tests++; if (o_data !== 4'h0) begin fails++; $display("FAIL reset_data: got %h want 0", o_data); end
        tests++; if (o_status !== 2'b00) begin fails++; $display("FAIL reset_status: got %b want 00", o_status); end
        tests++; if (o_err_pos !== 3'd0) begin fails++; $display("FAIL reset_err_pos: got %0d want 0", o_err_pos); end
        tests++; if (o_cnt_corr !== 2'd0 || o_cnt_uncorr !== 2'd0) begin
            fails++; $display("FAIL reset_counters: got %0d/%0d want 0/0", o_cnt_corr, o_cnt_uncorr);
        end
        i_rst_n = 1'b1;
        #1;
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_decode();
        vec_t vecs[9];
        vecs[0] = '{7'h55, 1'b0, 4'b1011, 2'b00, 3'd0, 2'd0, 2'd0}; // clean
        vecs[1] = '{7'h51, 1'b0, 4'b1011, 2'b01, 3'd3, 2'd1, 2'd0}; // d0 flipped
        vecs[2] = '{7'h55, 1'b1, 4'b1011, 2'b10, 3'd0, 2'd2, 2'd0}; // parity bit flipped
        vecs[3] = '{7'h56, 1'b0, 4'b1011, 2'b11, 3'd3, 2'd2, 2'd1}; // p1,p2 flipped
        vecs[4] = '{7'h54, 1'b0, 4'b1011, 2'b01, 3'd1, 2'd3, 2'd1}; // p1 flipped
        vecs[5] = '{7'h2A, 1'b1, 4'b0100, 2'b00, 3'd0, 2'd3, 2'd1}; // clean, other data
        vecs[6] = '{7'h6A, 1'b1, 4'b0100, 2'b01, 3'd7, 2'd3, 2'd1}; // d3 flipped, corr saturated
        vecs[7] = '{7'h22, 1'b1, 4'b0100, 2'b01, 3'd4, 2'd3, 2'd1}; // p4 flipped
        vecs[8] = '{7'h4A, 1'b1, 4'b1000, 2'b11, 3'd1, 2'd3, 2'd2}; // d2,d3 flipped
        i_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_hamming_code = vecs[k].code; i_parity = vecs[k].par;
            @(negedge clk);
            i_valid = 1'b0;
            @(negedge clk);
            tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL dec%0d_valid: got %b want 1", k, o_valid); end
            tests++; if (o_data !== vecs[k].d) begin fails++; $display("FAIL dec%0d_data: got %b want %b", k, o_data, vecs[k].d); end
            tests++; if (o_status !== vecs[k].st) begin fails++; $display("FAIL dec%0d_status: got %b want %b", k, o_status, vecs[k].st); end
            tests++; if (o_err_pos !== vecs[k].pos) begin fails++; $display("FAIL dec%0d_err_pos: got %0d want %0d", k, o_err_pos, vecs[k].pos); end
            @(negedge clk);
            tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL dec%0d_single: o_valid got %b want 0", k, o_valid); end
            tests++; if (o_cnt_corr !== vecs[k].corr) begin fails++; $display("FAIL dec%0d_cnt_corr: got %0d want %0d", k, o_cnt_corr, vecs[k].corr); end
            tests++; if (o_cnt_uncorr !== vecs[k].unc) begin fails++; $display("FAIL dec%0d_cnt_uncorr: got %0d want %0d", k, o_cnt_uncorr, vecs[k].unc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] codes [4] = '{7'h55, 7'h51, 7'h2A, 7'h6A};
        logic       pars  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_d [4] = '{4'b1011, 4'b1011, 4'b0100, 4'b0100};
        logic [1:0] exp_s [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        logic [2:0] exp_p [4] = '{3'd0, 3'd3, 3'd0, 3'd7};
        int tx = 0;
        int rx = 0;
        logic hold_prev = 1'b0;
        logic saw_stall = 1'b0;
        logic [3:0] prev_d = '0;
        logic [1:0] prev_s = '0;
        logic [2:0] prev_p = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            i_ready = !(cyc >= 3 && cyc < 8);
            if (tx < 4) begin
                i_valid = 1'b1; i_hamming_code = codes[tx]; i_parity = pars[tx];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (hold_prev) begin
                tests++;
                if (o_valid !== 1'b1 || o_data !== prev_d || o_status !== prev_s || o_err_pos !== prev_p) begin
                    fails++;
                    $display("FAIL bp_hold cyc%0d: got v=%b d=%b s=%b p=%0d want v=1 d=%b s=%b p=%0d",
                             cyc, o_valid, o_data, o_status, o_err_pos, prev_d, prev_s, prev_p);
                end
            end
            if (o_valid && i_ready) begin
                tests++;
                if (rx >= 4) begin
                    fails++; $display("FAIL bp_extra_word: got word %0d want only 4", rx);
                end else if (o_data !== exp_d[rx] || o_status !== exp_s[rx] || o_err_pos !== exp_p[rx]) begin
                    fails++;
                    $display("FAIL bp_word%0d: got d=%b s=%b p=%0d want d=%b s=%b p=%0d",
                             rx, o_data, o_status, o_err_pos, exp_d[rx], exp_s[rx], exp_p[rx]);
                end
                rx++;
            end
            hold_prev = o_valid && !i_ready;
            prev_d = o_data; prev_s = o_status; prev_p = o_err_pos;
            if (i_valid && !o_ready) saw_stall = 1'b1;
            if (i_valid && o_ready) tx++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tests++; if (rx !== 4) begin fails++; $display("FAIL bp_count: got %0d words want 4", rx); end
        tests++; if (saw_stall !== 1'b1) begin fails++; $display("FAIL bp_ready_drop: got %b want 1", saw_stall); end
    endtask

    task automatic test_counters();
        i_ready = 1'b1;
        @(negedge clk); i_cnt_clr = 1'b1;
        @(negedge clk); i_cnt_clr = 1'b0;
        tests++; if (o_cnt_corr !== 2'd0 || o_cnt_uncorr !== 2'd0) begin
            fails++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", o_cnt_corr, o_cnt_uncorr);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_hamming_code = 7'h51; i_parity = 1'b0;
        end
        @(negedge clk); i_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (o_cnt_corr !== 2'd3) begin fails++; $display("FAIL cnt_saturate: got %0d want 3", o_cnt_corr); end
        // clear in the same cycle as a corrected word's output handshake
        @(negedge clk); i_valid = 1'b1; i_hamming_code = 7'h51; i_parity = 1'b0;
        @(negedge clk); i_valid = 1'b0;
        @(negedge clk);
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL cnt_clr_setup: o_valid got %b want 1", o_valid); end
        i_cnt_clr = 1'b1;
        @(negedge clk); i_cnt_clr = 1'b0;
        tests++; if (o_cnt_corr !== 2'd0) begin fails++; $display("FAIL cnt_clr_wins: got %0d want 0", o_cnt_corr); end
        @(negedge clk); i_valid = 1'b1; i_hamming_code = 7'h55; i_parity = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (o_cnt_corr !== 2'd1) begin fails++; $display("FAIL cnt_resume: got %0d want 1", o_cnt_corr); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        @(negedge clk); i_valid = 1'b1; i_hamming_code = 7'h56; i_parity = 1'b0;
        @(negedge clk); i_hamming_code = 7'h55; i_parity = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        @(negedge clk);
        tests++; if (o_valid !== 1'b1 || o_cnt_uncorr !== 2'd1) begin
            fails++; $display("FAIL rst_mid_setup: got v=%b unc=%0d want v=1 unc=1", o_valid, o_cnt_uncorr);
        end
        i_rst_n = 1'b0;
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
        tests++; if (o_cnt_corr !== 2'd0 || o_cnt_uncorr !== 2'd0) begin
            fails++; $display("FAIL rst_mid_counters: got %0d/%0d want 0/0", o_cnt_corr, o_cnt_uncorr);
        end
        tests++; if (o_data !== 4'h0 || o_status !== 2'b00 || o_err_pos !== 3'd0) begin
            fails++; $display("FAIL rst_mid_outputs: got d=%b s=%b p=%0d want 0/0/0", o_data, o_status, o_err_pos);
        end
        @(negedge clk); i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_discard: o_valid got %b want 0", o_valid); end
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_valid        = 1'b0;
        i_hamming_code = '0;
        i_parity       = 1'b0;
        i_ready        = 1'b1;
        i_cnt_clr      = 1'b0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_counters();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hamming74_dec.md
Name: hamming74_dec

Overview:
- Pipelined SECDED decoder for the 7-bit Hamming(7,4) codeword plus overall even-parity bit produced by the team's Hamming(7,4) encoder.
- Corrects any single-bit error, including an error in the parity bit itself, and flags double-bit errors as uncorrectable.
- Uses a valid/ready handshake on both sides. Sits on the read side of ECC-protected storage and links.
- Keeps saturating counters of corrected and uncorrectable words for status and CSR readout.

Parameters:
- CNT_W, 16, width of each error counter (1..32).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input word valid.
- o_ready  output  1  decoder can accept an input word.
- i_hamming_code  input  7  codeword; bit order, LSB first: p1, p2, d0, p4, d1, d2, d3 (bit i = Hamming position i+1).
- i_parity  input  1  overall parity: XOR of the 7 transmitted code bits.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the output word.
- o_data  output  4  corrected data {d3,d2,d1,d0}.
- o_status  output  2  00 clean; 01 single error in code bit, corrected; 10 parity-bit-only error; 11 double error, uncorrectable.
- o_err_pos  output  3  syndrome: failing Hamming position 1..7, 0 if none.
- i_cnt_clr  input  1  synchronous clear of both counters.
- o_cnt_corr  output  CNT_W  count of status 01 and 10 words delivered.
- o_cnt_uncorr  output  CNT_W  count of status 11 words delivered.

Behaviour:
- Reset, asynchronous and active-low:
  - all pipeline valids 0, so o_valid = 0;
  - o_data, o_status, o_err_pos = 0;
  - both counters = 0.
  - Reset mid-operation discards in-flight words.
  - o_ready may be 1 in the first cycle after deassertion.
- Stage 1, registered, loaded on i_valid && o_ready:
  - s1 = c0^c2^c4^c6; s2 = c1^c2^c5^c6; s4 = c3^c4^c5^c6.
  - syn = {s4,s2,s1}.
  - pe = (^i_hamming_code) ^ i_parity.
  - Stores the code, syn and pe.
- Stage 2, registered, the output stage:
  - pe=0, syn=0: status 00, data unchanged.
  - pe=1, syn!=0: flip code bit syn-1, status 01.
  - pe=1, syn=0: status 10, data unchanged.
  - pe=0, syn!=0: status 11; o_data = uncorrected data bits; o_err_pos = syn (informational only).
  - Data extraction: {c6,c5,c4,c2}.
- Latency: 2 cycles from input handshake to o_valid when there is no backpressure. Sustained throughput is 1 word per cycle.
- Flow control:
  - adv2 = !v2 || i_ready.
  - adv1 = !v1 || adv2.
  - o_ready = adv1, combinational from i_ready; no skid buffer is required.
  - While o_valid && !i_ready, o_data, o_status and o_err_pos hold stable.
  - No word is dropped or duplicated.
- Counters:
  - Increment on the output handshake (o_valid && i_ready), according to o_status.
  - Saturate at 2^CNT_W-1; no wrap.
  - If i_cnt_clr and an increment occur in the same cycle, clear wins and the result is 0.
- i_valid with o_ready=0: the input must be held by the sender; the decoder does not sample it.

Decomposition:
- hamming_pkg:
  - status typedef/enum (ST_CLEAN, ST_CORR, ST_PAR, ST_DED);
  - bit-position localparams for p1, p2, d0, p4, d1, d2, d3;
  - syndrome width constant.
- The encoder's layout constants are moved into the same package.
- One sub-module: hamming74_syndrome. It is combinational and computes syn and pe from code + parity. It is reused by the stage-1 logic and by the testbench scoreboard.

Test Plan:
- Clean word: code 7'h55 (data 4'b1011), parity 0, i_ready=1 -> 2 cycles later o_data=4'b1011, status 00, err_pos 0; counters unchanged.
- Single data-bit error: code 7'h51 (bit 2 flipped), parity 0 -> o_data=4'b1011, status 01, err_pos 3, o_cnt_corr=1.
- Parity-bit error: code 7'h55, parity 1 -> o_data=4'b1011, status 10, err_pos 0, o_cnt_corr increments.
- Double error: code 7'h56 (bits 0,1 flipped), parity 0 -> status 11, err_pos 3, o_cnt_uncorr=1, o_cnt_corr unchanged.
- Backpressure: stream 4 words back-to-back with i_ready low for 5 cycles mid-stream -> o_ready drops once both stages are full, output holds stable, all 4 words emerge in order exactly once.
- Counter edges: with CNT_W=2, send 5 corrected words -> o_cnt_corr saturates at 3; assert i_cnt_clr in the same cycle as an accepted corrected word -> counter reads 0. Assert i_rst_n low mid-stream -> o_valid=0 immediately and both counters are 0.
